// File: rtl/rom_img_pkg.sv
// Shared definitions for the image ROM raster reader.
//   - Default image geometry and field widths.
//   - pix_beat_t: one pixel plus its coordinates and frame/line markers,
//     the unit stored in the output buffer.
//   - state_t: scan controller states.
package rom_img_pkg;

  localparam int DEF_WIDTH   = 256;
  localparam int DEF_HEIGHT  = 256;
  localparam int DEF_PIXEL_W = 8;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 8;

  typedef struct packed {
    logic [DEF_PIXEL_W-1:0] data;
    logic [DEF_X_W-1:0]     x;
    logic [DEF_Y_W-1:0]     y;
    logic                   sof;
    logic                   eol;
    logic                   eof;
  } pix_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO of pixel beats used as the reader's output buffer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears contents)
//   i_flush        : synchronous empty (pointers and count only)
//   i_push, i_beat : write a beat at the tail
//   i_pop          : remove the head beat (ignored when empty)
//   o_head         : current head beat
//   o_occ          : number of stored beats, 0..2
module pix_skid_fifo
  import rom_img_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  pix_beat_t   i_beat,
  input  logic        i_pop,
  output pix_beat_t   o_head,
  output logic [1:0]  o_occ
);

  pix_beat_t  r_mem [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_cnt;

  logic       w_pop;
  logic       w_push;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_beat;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head = r_mem[r_rd];
  assign o_occ  = r_cnt;

endmodule

// File: rtl/rom_raster_reader.sv
// Raster-scan reader for a synchronous image ROM (1-cycle latency, enable
// gated). Walks addresses 0..WIDTH*HEIGHT-1 row-major and presents each pixel
// on a valid/ready stream with x/y coordinates and sof/eol/eof markers.
// Reads are only issued while the 2-entry output buffer is guaranteed to have
// room for them, so backpressure never drops or duplicates a pixel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin a scan (when idle) / kill the scan
//   busy, done          : scan in progress / last pixel accepted this cycle
//   rom_en, rom_addr    : ROM read request
//   rom_data            : ROM read data, valid the cycle after rom_en
//   out_valid/out_ready : output stream handshake
//   out_data, out_x, out_y, out_sof, out_eol, out_eof : head pixel beat
module rom_raster_reader
  import rom_img_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIXEL_W-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_data,
  output logic [X_W-1:0]     out_x,
  output logic [Y_W-1:0]     out_y,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof
);

  state_t             r_state;
  state_t             w_state_nxt;

  // Issue pointer: address and the coordinates of that address.
  logic [ADDR_W-1:0]  r_addr;
  logic [X_W-1:0]     r_ix;
  logic [Y_W-1:0]     r_iy;

  // Beat metadata travelling alongside the outstanding ROM read.
  logic               r_inflight;
  logic [X_W-1:0]     r_x_p1;
  logic [Y_W-1:0]     r_y_p1;
  logic               r_sof_p1;
  logic               r_eol_p1;
  logic               r_eof_p1;

  logic               w_x_last;
  logic               w_y_last;
  logic               w_pop;
  logic               w_rom_en;
  logic               w_start_ok;
  logic               w_done;
  logic [2:0]         w_load;
  logic [1:0]         w_occ;
  pix_beat_t          w_head;
  pix_beat_t          w_tail;

  assign w_x_last = (r_ix == X_W'(WIDTH - 1));
  assign w_y_last = (r_iy == Y_W'(HEIGHT - 1));

  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Credit: buffered beats plus the read in flight, minus the beat leaving
  // now, must leave a free slot for the read issued this cycle.
  assign w_load   = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_rom_en = (r_state == ISSUE) && (w_load < (3'd2 + {2'b00, w_pop}));

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
          w_start_ok  = 1'b1;
        end
      end
      ISSUE: begin
        if (w_rom_en && w_x_last && w_y_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pop && w_head.eof) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
      w_start_ok  = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Issue pointer; holds on the final pixel instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_ix   <= '0;
      r_iy   <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
      r_ix   <= '0;
      r_iy   <= '0;
    end else if (w_rom_en && !(w_x_last && w_y_last)) begin
      r_addr <= r_addr + 1'b1;
      if (w_x_last) begin
        r_ix <= '0;
        r_iy <= r_iy + 1'b1;
      end else begin
        r_ix <= r_ix + 1'b1;
      end
    end
  end

  // ---- stage p1: ROM read in flight, metadata delayed to meet rom_data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_x_p1     <= '0;
      r_y_p1     <= '0;
      r_sof_p1   <= 1'b0;
      r_eol_p1   <= 1'b0;
      r_eof_p1   <= 1'b0;
    end else begin
      r_inflight <= w_rom_en && !abort;
      if (w_rom_en) begin
        r_x_p1   <= r_ix;
        r_y_p1   <= r_iy;
        r_sof_p1 <= (r_ix == '0) && (r_iy == '0);
        r_eol_p1 <= w_x_last;
        r_eof_p1 <= w_x_last && w_y_last;
      end
    end
  end

  // ---- stage p2: returning data joins its metadata at the buffer tail ----
  always_comb begin
    w_tail      = '0;
    w_tail.data = DEF_PIXEL_W'(rom_data);
    w_tail.x    = DEF_X_W'(r_x_p1);
    w_tail.y    = DEF_Y_W'(r_y_p1);
    w_tail.sof  = r_sof_p1;
    w_tail.eol  = r_eol_p1;
    w_tail.eof  = r_eof_p1;
  end

  pix_skid_fifo u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (abort),
    .i_push  (r_inflight),
    .i_beat  (w_tail),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  assign busy     = (r_state != IDLE);
  assign done     = w_done;
  assign rom_en   = w_rom_en;
  assign rom_addr = r_addr;
  assign out_data = PIXEL_W'(w_head.data);
  assign out_x    = X_W'(w_head.x);
  assign out_y    = Y_W'(w_head.y);
  assign out_sof  = w_head.sof;
  assign out_eol  = w_head.eol;
  assign out_eof  = w_head.eof;

endmodule

// File: tb/tb_rom_raster_reader.sv
// Bench for rom_raster_reader on a 4x3 image with a behavioural ROM.
// Expected beats are queued when a start is accepted; a monitor pops and
// compares on every stream transfer.
module tb_rom_raster_reader;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] x;
    logic [7:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } tb_beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_x;
  logic [7:0]  out_y;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;

  logic [7:0]  mem [16];
  tb_beat_t    q [$];
  bit          m_busy = 1'b0;
  int          n_iss = 0;
  int          n_acc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          prev_stall = 1'b0;
  tb_beat_t    prev_head;

  always #5 clk = ~clk;

  rom_raster_reader #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_W(8), .ADDR_W(16), .X_W(8), .Y_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  // Synchronous ROM, one-cycle latency, enable gated.
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr[3:0]];

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from the raster rules: beat i is pixel (i%W, i/W).
  task automatic push_frame();
    tb_beat_t b;
    for (int i = 0; i < N; i++) begin
      b.data = mem[i];
      b.x    = 8'(i % W);
      b.y    = 8'(i / W);
      b.sof  = (i == 0);
      b.eol  = ((i % W) == W - 1);
      b.eof  = (i == N - 1);
      q.push_back(b);
    end
  endtask

  // One-cycle start pulse; accepted only when the model is idle and no abort.
  task automatic pulse_start();
    start = 1'b1;
    if (!m_busy && !abort) begin
      push_frame();
      m_busy = 1'b1;
      n_iss  = 0;
      n_acc  = 0;
    end
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0, 2: random ~70% ready
  task automatic wait_idle(input int mode, input int bound);
    int k;
    k = 0;
    while ((m_busy || busy) && k < bound) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k % 3) == 0);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      tick();
      k++;
    end
    chk(k < bound, "idle_timeout", k, bound);
    chk(q.size() == 0, "beats_missing", q.size(), 0);
    out_ready = 1'b1;
  endtask

  function automatic longint all_outs();
    return longint'({busy, done, rom_en, rom_addr, out_valid, out_data,
                     out_x, out_y, out_sof, out_eol, out_eof});
  endfunction

  // Monitor: compares every transfer against the expected queue.
  always @(negedge clk) begin
    tb_beat_t act;
    tb_beat_t exp;
    act = {out_data, out_x, out_y, out_sof, out_eol, out_eof};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rom_en) n_iss++;
      if (out_valid && out_ready) begin
        n_acc++;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_beat", longint'(act), 0);
        end else begin
          exp = q.pop_front();
          chk(act === exp, "beat", longint'(act), longint'(exp));
          chk(done === exp.eof, "done_on_eof", done, exp.eof);
          if (exp.eof) begin
            chk(n_iss == N, "reads_per_frame", n_iss, N);
            m_busy = 1'b0;
          end
        end
      end else begin
        chk(done === 1'b0, "done_idle", done, 0);
      end
      if (prev_stall) begin
        chk(out_valid === 1'b1, "stall_valid", out_valid, 1);
        chk(act === prev_head, "stall_stable", longint'(act), longint'(prev_head));
      end
      chk(n_iss - n_acc <= 2, "credit", n_iss - n_acc, 2);
      chk(dut.w_occ <= 2'd2, "occupancy", dut.w_occ, 2);
      prev_stall = out_valid && !out_ready && !abort;
      prev_head  = act;
      if (abort) begin
        q.delete();
        m_busy = 1'b0;
        n_iss  = 0;
        n_acc  = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    tick(); tick();
    chk(all_outs() == 0, "reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    tick();
    chk(busy === 1'b0 && rom_en === 1'b0, "idle_after_reset", {busy, rom_en}, 0);

    // Full-rate scan with latency and done/busy timing.
    out_ready = 1'b1;
    pulse_start();                                   // now cycle 1
    chk(rom_en === 1'b1 && rom_addr == 16'd0, "first_read", {rom_en, rom_addr}, 17'h10000);
    tick();                                          // cycle 2
    chk(out_valid === 1'b0, "valid_cycle2", out_valid, 0);
    chk(rom_addr == 16'd1, "addr_cycle2", rom_addr, 1);
    tick();                                          // cycle 3
    chk(out_valid === 1'b1, "valid_cycle3", out_valid, 1);
    repeat (11) tick();                              // cycle 14
    chk(done === 1'b1 && busy === 1'b1, "done_cycle14", {done, busy}, 3);
    tick();                                          // cycle 15
    chk(busy === 1'b0, "busy_drop", busy, 0);
    wait_idle(0, 50);

    // Backpressure 1,0,0 pattern.
    pulse_start();
    wait_idle(1, 400);

    // Long stall: only two reads while the sink refuses.
    out_ready = 1'b0;
    pulse_start();
    repeat (19) tick();
    chk(n_iss == 2, "stall_reads", n_iss, 2);
    chk(out_valid === 1'b1, "stall_hold_valid", out_valid, 1);
    chk(out_data == mem[0], "stall_hold_data", out_data, mem[0]);
    wait_idle(0, 100);

    // Abort at beat 5.
    out_ready = 1'b1;
    pulse_start();
    repeat (7) tick();                               // cycle 8: beat 5 on the bus
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk(out_valid === 1'b0 && busy === 1'b0 && done === 1'b0, "abort_next",
        {out_valid, busy, done}, 0);
    repeat (3) tick();
    chk(out_valid === 1'b0, "abort_flushed", out_valid, 0);
    abort = 1'b1;                                    // abort beats start
    pulse_start();
    abort = 1'b0;
    chk(busy === 1'b0, "abort_over_start", busy, 0);
    pulse_start();
    wait_idle(0, 100);

    // Extra starts at beat 4 and in the done cycle are ignored.
    pulse_start();                                   // cycle 1
    repeat (6) tick();                               // cycle 7
    pulse_start();                                   // cycle 8
    repeat (6) tick();                               // cycle 14
    chk(done === 1'b1, "done_with_start", done, 1);
    pulse_start();                                   // cycle 15
    chk(busy === 1'b0, "start_in_done_ignored", busy, 0);
    wait_idle(0, 100);

    // Asynchronous reset mid-scan.
    pulse_start();
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    q.delete();
    m_busy = 1'b0;
    #1;
    chk(all_outs() == 0, "async_reset_outputs", all_outs(), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk({busy, out_valid, rom_en} == 3'b000, "idle_after_rerelease", {busy, out_valid, rom_en}, 0);

    // Random ROM contents and random backpressure.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      pulse_start();
      wait_idle(2, 600);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/rom_raster_reader.md
Name: rom_raster_reader

Overview:
- Sequences the synchronous image ROM (1-cycle read latency, enable-gated) through a full raster scan: address 0 .. WIDTH*HEIGHT-1, row-major.
- Presents pixels as a valid/ready stream with x/y coordinates and frame/line markers to the downstream filament/sunspot detection pipeline.
- Absorbs ROM latency under backpressure with a 2-entry output buffer, so it never drops or duplicates a pixel.

Parameters:
WIDTH, 256, image width in pixels (>=2)
HEIGHT, 256, image height in pixels (>=2)
PIXEL_W, 8, bits per pixel
ADDR_W, 16, ROM address width, >= clog2(WIDTH*HEIGHT)
X_W, 8, x coordinate width, >= clog2(WIDTH)
Y_W, 8, y coordinate width, >= clog2(HEIGHT)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin a frame scan (ignored while busy)
abort  in  1  synchronous; kill the current scan and return to IDLE
busy  out  1  high from the cycle after an accepted start until done or abort
done  out  1  one-cycle pulse in the cycle the last pixel is accepted downstream
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  PIXEL_W  ROM data, valid the cycle after rom_en
out_valid  out  1  stream valid
out_ready  in  1  stream ready; transfer when out_valid && out_ready
out_data  out  PIXEL_W  pixel value
out_x  out  X_W  column 0..WIDTH-1
out_y  out  Y_W  row 0..HEIGHT-1
out_sof  out  1  marks pixel (0,0)
out_eol  out  1  marks x==WIDTH-1
out_eof  out  1  marks pixel (WIDTH-1,HEIGHT-1)

Behaviour:
- Reset (async, rst_n=0) drives all outputs to 0: busy, done, rom_en, rom_addr, out_valid, out_data, out_x, out_y, markers. It also clears the state, counters and buffer.
- FSM states:
  - IDLE: start=1 -> ISSUE; issue pointer reset to addr 0, x=0, y=0.
  - ISSUE: issues reads while credit allows. After issuing the last address -> DRAIN.
  - DRAIN: no new reads. When the last pixel (eof) is accepted, done=1 for that cycle -> IDLE.
  - abort=1 in any state -> IDLE next cycle. The buffer and in-flight read are flushed; out_valid=0 next cycle; done not asserted. abort has priority over start in the same cycle.
- Credit rule: rom_en=1 in a cycle iff state==ISSUE and (occupancy + inflight - pop) < 2.
  - occupancy = buffer entries (0..2); inflight = rom_en of the previous cycle; pop = out_valid && out_ready.
  - With out_ready held high this gives one pixel per clock.
- rom_addr is combinational from the issue pointer. The pointer increments only on rom_en=1.
- Coordinates and markers are computed at issue time, delayed one cycle alongside the read, then written with rom_data into the buffer tail.
- x wraps WIDTH-1 -> 0 with y+1. No wrap after the last pixel.
- Buffer is a FIFO.
  - out_* reflects the head; out_valid = occupancy != 0.
  - Push and pop in the same cycle are allowed. Overflow is impossible by the credit rule; the bench asserts occupancy <= 2.
  - Head fields are stable while out_valid && !out_ready.
- Latency: start at cycle 0 -> rom_en at cycle 1 -> out_valid at cycle 3 (ROM read cycle 2, buffer write).
- start while busy: ignored, no effect.
- start in the same cycle as done: ignored; the controller is still busy that cycle.
- busy=1 in ISSUE and DRAIN, 0 in IDLE.

Decomposition:
- Shared package rom_img_pkg:
  - image dimension defaults, address/coordinate widths;
  - a pixel-beat struct {data, x, y, sof, eol, eof};
  - FSM state enum {IDLE, ISSUE, DRAIN}.
- One sub-module: pix_skid_fifo. It is a 2-entry FIFO of pixel-beat structs with push/pop, occupancy output and a synchronous flush, used by the controller for the output buffer.
- The ROM stays external; the top-level bench wires rom_raster_reader to rom_image.

Test Plan (WIDTH=4, HEIGHT=3, ROM preloaded with mem[i]=i):
- Full-rate scan: start pulse, out_ready=1 -> 12 beats on consecutive cycles, first at cycle 3.
  - data 0..11, x=i%4, y=i/4.
  - sof on beat 0; eol on beats 3, 7, 11; eof on beat 11.
  - done on the beat-11 cycle; busy drops next cycle.
- Backpressure: out_ready toggles 1,0,0,1,... -> same 12 beats in order, no duplicates or drops; head held stable while stalled; occupancy never >2; rom_en idle while credit is exhausted.
- Long stall: out_ready=0 for 20 cycles after start -> exactly 2 rom_en pulses; out_valid=1 holding data 0. On release, the stream resumes at 1,2,...
- Abort mid-frame: abort at beat 5 -> next cycle out_valid=0, busy=0, no done. A new start then rescans from data 0 with sof.
- Start while busy / start with done: extra start pulses at beat 4 and at the done cycle -> ignored, exactly 12 beats per real start.
- Async reset mid-scan: rst_n=0 at beat 6 -> all outputs 0 immediately (no clock edge needed). After release, the controller stays idle until start.
